// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Operand-fetch stage for ARM data-processing words. Reads Rn/Rm
//             from the register file, tracks outstanding destination writes
//             in a 16-bit pending scoreboard, stalls on read-after-write
//             hazards and holds a registered bundle for the execute stage.
//  Options  : OF_BYPASS_EN - when defined, a pending source that is being
//             retired by the writeback port in the same cycle is forwarded
//             from wb_data instead of stalling.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  read_addr1,
    output logic [3:0]  read_addr2,
    output logic        read_enable1,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        wb_valid,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_op_a,
    output logic [31:0] ex_op_b,
    output logic [3:0]  ex_dest,
    output logic [3:0]  ex_opcode,
    output logic [3:0]  ex_cond,
    output logic        ex_s,
    output logic        ex_imm_en,
    output logic        ex_wr_en
);

    // Instruction field decode
    logic        w_imm;
    logic [3:0]  w_opcode;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;
    logic        w_wr_en;
    logic        w_unused_bits;

    assign w_imm    = instr[25];
    assign w_opcode = instr[24:21];
    assign w_rn     = instr[19:16];
    assign w_rd     = instr[15:12];
    assign w_rm     = instr[3:0];
    // TST/TEQ/CMP/CMN (1000..1011) only update flags, never a register
    assign w_wr_en  = (w_opcode[3:2] != 2'b10);
    // Bits 27:26 are the data-processing class field, fixed by decode upstream
    assign w_unused_bits = ^instr[27:26];

    assign read_addr1   = w_rn;
    assign read_addr2   = w_rm;
    assign read_enable1 = instr_valid;

    // Scoreboard and held execute bundle
    logic [15:0] r_pending;
    logic [15:0] w_pending_next;
    logic        r_ex_valid;
    logic [31:0] r_ex_op_a;
    logic [31:0] r_ex_op_b;
    logic [3:0]  r_ex_dest;
    logic [3:0]  r_ex_opcode;
    logic [3:0]  r_ex_cond;
    logic        r_ex_s;
    logic        r_ex_imm_en;
    logic        r_ex_wr_en;

    // Hazard detection: Rn is always a source, Rm only for register operand 2
    logic        w_rn_pend;
    logic        w_rm_pend;
    logic        w_rn_fwd;
    logic        w_rm_fwd;
    logic        w_hazard;
    logic        w_accept;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;

    assign w_rn_pend = r_pending[w_rn];
    assign w_rm_pend = !w_imm && r_pending[w_rm];

`ifdef OF_BYPASS_EN
    // A pending source retiring this very cycle is taken straight off the wb port
    assign w_rn_fwd = w_rn_pend && wb_valid && (wb_addr == w_rn);
    assign w_rm_fwd = w_rm_pend && wb_valid && (wb_addr == w_rm);
`else
    // No forwarding: the source is picked up from the file the cycle after retire
    assign w_rn_fwd = 1'b0;
    assign w_rm_fwd = 1'b0;
`endif

    assign w_hazard = instr_valid &&
                      ((w_rn_pend && !w_rn_fwd) || (w_rm_pend && !w_rm_fwd));

    // Reset forces ready low so nothing is accepted while state is cleared
    assign instr_ready = rst && !w_hazard && (!r_ex_valid || ex_ready) && !flush;
    assign w_accept    = instr_valid && instr_ready;

    assign w_src_a = w_rn_fwd ? wb_data : read_data1;
    assign w_src_b = w_imm    ? {20'd0, instr[11:0]}
                   : (w_rm_fwd ? wb_data : read_data2);

    // Next scoreboard: retire and flush clear first, so a same-edge set wins
    always_comb begin
        w_pending_next = r_pending;
        if (wb_valid) begin
            w_pending_next[wb_addr] = 1'b0;
        end
        if (flush && r_ex_valid && r_ex_wr_en) begin
            w_pending_next[r_ex_dest] = 1'b0;
        end
        if (w_accept && w_wr_en) begin
            w_pending_next[w_rd] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= 16'd0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Execute bundle: load on accept, drop on flush or on downstream take
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_op_a   <= 32'd0;
            r_ex_op_b   <= 32'd0;
            r_ex_dest   <= 4'd0;
            r_ex_opcode <= 4'd0;
            r_ex_cond   <= 4'd0;
            r_ex_s      <= 1'b0;
            r_ex_imm_en <= 1'b0;
            r_ex_wr_en  <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid  <= 1'b1;
            r_ex_op_a   <= w_src_a;
            r_ex_op_b   <= w_src_b;
            r_ex_dest   <= w_rd;
            r_ex_opcode <= w_opcode;
            r_ex_cond   <= instr[31:28];
            r_ex_s      <= instr[20];
            r_ex_imm_en <= w_imm;
            r_ex_wr_en  <= w_wr_en;
        end else if (flush || ex_ready) begin
            r_ex_valid  <= 1'b0;
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_op_a   = r_ex_op_a;
    assign ex_op_b   = r_ex_op_b;
    assign ex_dest   = r_ex_dest;
    assign ex_opcode = r_ex_opcode;
    assign ex_cond   = r_ex_cond;
    assign ex_s      = r_ex_s;
    assign ex_imm_en = r_ex_imm_en;
    assign ex_wr_en  = r_ex_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Purpose  : Directed self-checking bench for operand_fetch with a
//             transaction-level reference model (scoreboard array plus a
//             queue holding the execute entry) and literal spot checks.
//  Options  : honours OF_BYPASS_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  read_addr1;
    logic [3:0]  read_addr2;
    logic        read_enable1;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [3:0]  ex_dest;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_cond;
    logic        ex_s;
    logic        ex_imm_en;
    logic        ex_wr_en;

    int total = 0;
    int bad   = 0;

    operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_enable1 (read_enable1),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op_a      (ex_op_a),
        .ex_op_b      (ex_op_b),
        .ex_dest      (ex_dest),
        .ex_opcode    (ex_opcode),
        .ex_cond      (ex_cond),
        .ex_s         (ex_s),
        .ex_imm_en    (ex_imm_en),
        .ex_wr_en     (ex_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file, written by the writeback port
    logic [31:0] regs [16];
    assign read_data1 = regs[read_addr1];
    assign read_data2 = regs[read_addr2];

    // Reference model state
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dest;
        logic [3:0]  opc;
        logic [3:0]  cond;
        logic        s;
        logic        imm;
        logic        wr;
    } entry_t;

    entry_t held[$];
    bit     pend[16];
    bit     started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input bit i, input logic [3:0] opc, input bit s,
                                       input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] op2);
        return {4'hE, 2'b00, i, opc, s, rn, rd, op2};
    endfunction

    function automatic bit writes_reg(input logic [31:0] w);
        return !(w[24:21] inside {[4'd8:4'd11]});
    endfunction

    function automatic bit bypassed(input logic [3:0] r);
`ifdef OF_BYPASS_EN
        return pend[r] && wb_valid && (wb_addr == r);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit blocked(input logic [31:0] w);
        bit b;
        b = pend[w[19:16]] && !bypassed(w[19:16]);
        if (!w[25] && pend[w[3:0]] && !bypassed(w[3:0])) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] operand(input logic [3:0] r);
        return bypassed(r) ? wb_data : regs[r];
    endfunction

    function automatic bit exp_ready();
        if (!rst || flush) return 1'b0;
        if (held.size() != 0 && !ex_ready) return 1'b0;
        if (instr_valid && blocked(instr)) return 1'b0;
        return 1'b1;
    endfunction

    // Model advance at each clock edge, mirroring the intended transaction flow
    always @(posedge clk) begin
        bit     acc;
        entry_t e;
        e = '0;
        if (!started) begin
            foreach (regs[i]) regs[i] <= 32'h1000 + i;
            regs[2] <= 32'd5;
            regs[3] <= 32'd7;
        end
        if (!rst) begin
            held.delete();
            foreach (pend[i]) pend[i] = 1'b0;
        end else begin
            acc = instr_valid && exp_ready();
            if (acc) begin
                e.a    = operand(instr[19:16]);
                e.b    = instr[25] ? {20'd0, instr[11:0]} : operand(instr[3:0]);
                e.dest = instr[15:12];
                e.opc  = instr[24:21];
                e.cond = instr[31:28];
                e.s    = instr[20];
                e.imm  = instr[25];
                e.wr   = writes_reg(instr);
            end
            if (wb_valid) pend[wb_addr] = 1'b0;
            if (flush && held.size() != 0 && held[0].wr) pend[held[0].dest] = 1'b0;
            if (acc && e.wr) pend[instr[15:12]] = 1'b1;
            if (flush) held.delete();
            else if (held.size() != 0 && ex_ready) void'(held.pop_front());
            if (acc) held.push_back(e);
        end
        if (wb_valid) regs[wb_addr] <= wb_data;
        started = 1'b1;
    end

    // Compare DUT against the model on the falling edge of every cycle
    always @(negedge clk) begin
        if (started) begin
            check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready()});
            check("read_addr1", {28'd0, read_addr1}, {28'd0, instr[19:16]});
            check("read_addr2", {28'd0, read_addr2}, {28'd0, instr[3:0]});
            check("read_enable1", {31'd0, read_enable1}, {31'd0, instr_valid});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, held.size() != 0});
            if (held.size() != 0) begin
                check("ex_op_a", ex_op_a, held[0].a);
                check("ex_op_b", ex_op_b, held[0].b);
                check("ex_dest", {28'd0, ex_dest}, {28'd0, held[0].dest});
                check("ex_opcode", {28'd0, ex_opcode}, {28'd0, held[0].opc});
                check("ex_cond", {28'd0, ex_cond}, {28'd0, held[0].cond});
                check("ex_flags", {29'd0, ex_s, ex_imm_en, ex_wr_en},
                      {29'd0, held[0].s, held[0].imm, held[0].wr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input bit er);
        instr_valid = v;
        instr       = w;
        ex_ready    = er;
    endtask

    task automatic wb(input bit v, input logic [3:0] a, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd2, 4'd1, 12'h003), 1'b1);
        wb(1'b1, 4'd9, 32'hDEAD_0009);
        tick();
        tick();
        // Reset state
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_op_a", ex_op_a, 32'd0);
        check("rst_op_b", ex_op_b, 32'd0);
        check("rst_fields", {16'd0, ex_dest, ex_opcode, ex_cond, 1'b0, ex_s, ex_imm_en, ex_wr_en}, 32'd0);
        wb(1'b0, 4'd0, 32'd0);
        rst = 1'b1;

        // ADD R1,R2,R3
        #1 check("add_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_op_a", ex_op_a, 32'd5);
        check("add_op_b", ex_op_b, 32'd7);
        check("add_dest", {28'd0, ex_dest}, 32'd1);
        check("add_wr", {31'd0, ex_wr_en}, 32'd1);

        // ADD R4,R1,#3 waits on R1
        drive(1'b1, mk(1'b1, 4'h4, 1'b0, 4'd1, 4'd4, 12'd3), 1'b1);
        #1 check("raw_stall0", {31'd0, instr_ready}, 32'd0);
        tick();
        check("raw_stall1", {31'd0, instr_ready}, 32'd0);
        wb(1'b1, 4'd1, 32'h55);
`ifdef OF_BYPASS_EN
        #1 check("byp_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        wb(1'b0, 4'd0, 32'd0);
`else
        #1 check("nobyp_stall", {31'd0, instr_ready}, 32'd0);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        #1 check("nobyp_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
`endif
        check("raw_op_a", ex_op_a, 32'h55);
        check("raw_op_b", ex_op_b, 32'd3);
        check("raw_dest", {28'd0, ex_dest}, 32'd4);

        // CMP R1,#0 does not write, so a later R1 reader is not stalled
        drive(1'b1, mk(1'b1, 4'hA, 1'b1, 4'd1, 4'd0, 12'd0), 1'b1);
        tick();
        check("cmp_wr", {31'd0, ex_wr_en}, 32'd0);
        check("cmp_op_a", ex_op_a, 32'h55);
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd1, 4'd5, 12'h001), 1'b1);
        #1 check("cmp_no_stall", {31'd0, instr_ready}, 32'd1);
        tick();

        // Back-pressure for three cycles
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd2, 4'd7, 12'h003), 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", {31'd0, instr_ready}, 32'd0);
            tick();
            check("bp_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_dest", {28'd0, ex_dest}, 32'd5);
            check("bp_op_b", ex_op_b, 32'h55);
        end
        ex_ready = 1'b1;
        #1 check("bp_release", {31'd0, instr_ready}, 32'd1);
        tick();
        check("bp_new_dest", {28'd0, ex_dest}, 32'd7);
        check("bp_new_op_a", ex_op_a, 32'd5);

        // Flush a held ADD R6
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd2, 4'd6, 12'h003), 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b1, mk(1'b1, 4'h4, 1'b0, 4'd6, 4'd8, 12'd0), 1'b0);
        flush = 1'b1;
        #1 check("flush_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        flush = 1'b0;
        ex_ready = 1'b1;
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        #1 check("flush_r6_clear", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        check("flush_next_op_a", ex_op_a, 32'h1006);

        // Same-edge retire and new set of R6: set wins
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd2, 4'd6, 12'h003), 1'b1);
        tick();
        drive(1'b1, mk(1'b1, 4'h4, 1'b0, 4'd2, 4'd6, 12'd1), 1'b1);
        wb(1'b1, 4'd6, 32'h66);
        #1 check("same_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        wb(1'b0, 4'd0, 32'd0);
        drive(1'b1, mk(1'b1, 4'h4, 1'b0, 4'd6, 4'd9, 12'd0), 1'b1);
        #1 check("same_r6_pending", {31'd0, instr_ready}, 32'd0);
        tick();
        wb(1'b1, 4'd6, 32'h77);
`ifdef OF_BYPASS_EN
        tick();
        drive(1'b0, 32'd0, 1'b1);
        wb(1'b0, 4'd0, 32'd0);
`else
        tick();
        wb(1'b0, 4'd0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 1'b1);
`endif
        check("r9_op_a", ex_op_a, 32'h77);
        check("r9_dest", {28'd0, ex_dest}, 32'd9);

        // Reset while an entry is held
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd2, 4'd10, 12'h003), 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_valid", {31'd0, ex_valid}, 32'd0);
        check("midrst_op_a", ex_op_a, 32'd0);
        check("midrst_dest", {28'd0, ex_dest}, 32'd0);
        rst = 1'b1;
        drive(1'b1, mk(1'b0, 4'h4, 1'b0, 4'd4, 4'd11, 12'h005), 1'b1);
        #1 check("midrst_pend_clear", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        check("post_op_a", ex_op_a, 32'h1004);
        check("post_op_b", ex_op_b, 32'h1005);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have the ports below; one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-004 instr_valid  in  1  upstream instruction word valid.
REQ-005 instr  in  32  ARM data-processing word: cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], imm12/Rm[11:0].
REQ-006 instr_ready  out  1  block accepts instr this cycle.
REQ-007 read_addr1 / read_addr2  out  4 each  to register file: Rn and Rm.
REQ-008 read_enable1  out  1  register-file read enable.
REQ-009 read_data1 / read_data2  in  32 each  combinational register-file read data.
REQ-010 wb_valid, wb_addr[3:0], wb_data[31:0]  in  writeback-stage retire of register wb_addr.
REQ-011 flush  in  1  discard held output entry.
REQ-012 ex_valid  out  1; ex_ready  in  1  downstream handshake.
REQ-013 ex_op_a[31:0], ex_op_b[31:0], ex_dest[3:0], ex_opcode[3:0], ex_cond[3:0], ex_s, ex_imm_en, ex_wr_en  out  registered execute-stage bundle.

Function
REQ-014 read_addr1 SHALL equal instr[19:16], read_addr2 instr[3:0], combinationally; read_enable1 = instr_valid.
REQ-015 Source use: Rn always; Rm only when I=0; dest write ex_wr_en = 0 for opcode 1000-1011 (TST/TEQ/CMP/CMN), else 1.
REQ-016 Scoreboard: 16-bit pending vector; bit set at accept edge when accepted instruction has wr_en=1 (bit Rd); bit cleared at edge where wb_valid=1 (bit wb_addr).
REQ-017 Hazard = instr_valid and a used source has pending bit set (subject to REQ-027).
REQ-018 instr_ready = !hazard and (!ex_valid or ex_ready) and !flush.
REQ-019 Accept = instr_valid and instr_ready; output bundle SHALL load at that edge; ex_valid=1 the following cycle (latency 1).
REQ-020 ex_op_a = read_data1; ex_op_b = I ? zero-extended imm12 (no rotate) : read_data2.
REQ-021 Held bundle SHALL stay stable while ex_valid=1 and ex_ready=0; ex_valid clears on ex_valid and ex_ready without a new accept.
REQ-022 Simultaneous set and clear of the same pending bit: set wins.
REQ-023 flush=1: ex_valid cleared next edge; pending bit of the flushed entry's dest (if ex_wr_en) cleared same edge; no accept that cycle.
REQ-024 Pending bits are written only at accept/retire/flush edges; instructions not accepted leave state untouched.

Reset
REQ-025 rst=0 at a rising edge: ex_valid=0, pending=0, ex_op_a/ex_op_b=0, ex_dest/ex_opcode/ex_cond=0, ex_s/ex_imm_en/ex_wr_en=0; held entry dropped mid-operation.
REQ-026 During reset cycle instr_ready=0; wb inputs ignored.

Configuration
REQ-027 Macro OF_BYPASS_EN defined: a pending source matching wb_addr while wb_valid=1 is not a hazard; operand taken from wb_data instead of read_data; undefined: such source stalls, accepted one cycle later from the register file.

Verification
REQ-028 Reset, then instr ADD R1,R2,R3 (R2=5,R3=7 in file), ex_ready=1 -> ex_valid next cycle, ex_op_a=5, ex_op_b=7, ex_dest=1, ex_wr_en=1.
REQ-029 ADD R1 accepted, next ADD R4,R1,#3 with no wb -> instr_ready=0 until wb_valid, wb_addr=1; with OF_BYPASS_EN accept in wb cycle, ex_op_a=wb_data; without, accept one cycle later.
REQ-030 CMP R1,#0 issued -> ex_wr_en=0, pending[1] unchanged; following instruction reading R1 not stalled.
REQ-031 ex_ready=0 for 3 cycles with ex_valid=1 -> bundle unchanged, instr_ready=0; ex_ready=1 -> new entry next cycle.
REQ-032 flush while holding ADD R6 -> ex_valid=0 next cycle, pending[6]=0; same-cycle wb of R6 and accept writing R6 -> pending[6]=1.
